fifo_tx_sync_ctrl: RTL and testbench



---
 rtl/fifo_tx_sync_ctrl.sv | 87 ++++++++
 tb/tb_fifo_tx_sync_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_sync_ctrl.sv
// fifo_tx_sync_ctrl: FIFO controller for a 1-cycle-latency SDP RAM with a 2-entry
// prefetch buffer presenting a first-word-fall-through valid/pop interface.
module fifo_tx_sync_ctrl #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int AFULL_TH = 1008
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          afull,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [AW+1:0] level,
    output logic          ovf,
    output logic          udf,
    input  logic          err_clr,
    output logic          ram_cew,
    output logic [AW-1:0] ram_aw,
    output logic [DW-1:0] ram_dw,
    output logic          ram_cer,
    output logic [AW-1:0] ram_ar,
    input  logic [DW-1:0] ram_qr
);
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   ram_cnt;
    logic          inflight;
    logic [1:0]    ob_cnt;
    logic [DW-1:0] ob0, ob1;
    logic          wr_acc, pop_acc, rd_iss, tail;
    logic [2:0]    ob_need;

    assign full    = ram_cnt == {1'b1, {AW{1'b0}}};
    assign valid   = ob_cnt != 2'd0;
    assign dout    = ob0;
    assign level   = (AW+2)'(ram_cnt) + (AW+2)'(inflight) + (AW+2)'(ob_cnt);
    assign afull   = level >= (AW+2)'(AFULL_TH);
    assign wr_acc  = push & !full & !flush;
    assign pop_acc = pop & valid & !flush;
    // Slots already committed (held or in flight) after this cycle's pop.
    assign ob_need = {1'b0, ob_cnt} + {2'b0, inflight} - {2'b0, pop_acc};
    assign rd_iss  = (ram_cnt != '0) && (ob_need < 3'd2) && !flush;
    // Tail slot for captured data: ob_cnt - pop_acc, which is only ever 0 or 1.
    assign tail    = ob_cnt[0] ^ pop_acc;
    assign ram_cew = wr_acc;
    assign ram_aw  = wptr;
    assign ram_dw  = din;
    assign ram_cer = rd_iss;
    assign ram_ar  = rptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            ob_cnt   <= '0;
            ob0      <= '0;
            ob1      <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            ovf <= (ovf & !err_clr) | (push & full & !flush);
            udf <= (udf & !err_clr) | (pop & !valid & !flush);
            if (flush) begin
                wptr     <= '0;
                rptr     <= '0;
                ram_cnt  <= '0;
                inflight <= 1'b0;
                ob_cnt   <= '0;
            end else begin
                wptr     <= wptr + AW'(wr_acc);
                rptr     <= rptr + AW'(rd_iss);
                ram_cnt  <= ram_cnt + (AW+1)'(wr_acc) - (AW+1)'(rd_iss);
                inflight <= rd_iss;
                ob_cnt   <= ob_cnt + {1'b0, inflight} - {1'b0, pop_acc};
                if (pop_acc) ob0 <= ob1;
                if (inflight && tail) ob1 <= ram_qr;
                if (inflight && !tail) ob0 <= ram_qr;
            end
        end
    end
endmodule

// File: tb/tb_fifo_tx_sync_ctrl.sv
// tb_fifo_tx_sync_ctrl: scoreboard bench with a behavioural 1024x32 RAM; pushed words
// queue as expected data and a monitor checks every accepted pop.
module tb_fifo_tx_sync_ctrl;
    logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [31:0] din = '0, dout, ram_dw, ram_qr;
    logic        full, afull, valid, ovf, udf, ram_cew, ram_cer;
    logic [11:0] level;
    logic [9:0]  ram_aw, ram_ar;
    logic [31:0] mem [1024];
    logic [31:0] exp_q [$];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    fifo_tx_sync_ctrl dut (
        .clk(clk), .rstn(rstn), .flush(flush), .push(push), .din(din), .full(full),
        .afull(afull), .pop(pop), .dout(dout), .valid(valid), .level(level), .ovf(ovf),
        .udf(udf), .err_clr(err_clr), .ram_cew(ram_cew), .ram_aw(ram_aw), .ram_dw(ram_dw),
        .ram_cer(ram_cer), .ram_ar(ram_ar), .ram_qr(ram_qr)
    );

    always @(posedge clk) begin
        if (ram_cew) mem[ram_aw] <= ram_dw;
        if (ram_cer) ram_qr <= mem[ram_ar];
    end

    always @(negedge clk) begin
        if (rstn && valid && pop && !flush) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_data: got %0h with no word expected", dout);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    miscompares++;
                    $display("FAIL pop_data: got %0h expected %0h", dout, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        push = 1'b1;
        din  = d;
        exp_q.push_back(d);
        cyc();
        push = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
            pop = valid;
            cyc();
        end
        pop = 1'b0;
        chk("drain_left", 64'(exp_q.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_level", level, 0);
        chk("rst_flags", {full, afull, ovf, udf}, 0);
        chk("rst_ram_en", {ram_cew, ram_cer}, 0);
        chk("rst_dout", dout, 0);
        rstn = 1'b1;
        cyc();

        // single word
        push = 1'b1;
        din  = 32'hA5A5_0001;
        exp_q.push_back(din);
        #1;
        chk("sw_cew", {ram_cew, ram_aw}, {1'b1, 10'd0});
        chk("sw_dw", ram_dw, 32'hA5A5_0001);
        cyc();
        push = 1'b0;
        #1;
        chk("sw_cer", {ram_cer, ram_ar}, {1'b1, 10'd0});
        cyc();
        #1;
        chk("sw_c2_valid", valid, 0);
        chk("sw_c2_level", level, 1);
        cyc();
        #1;
        chk("sw_c3_valid", valid, 1);
        chk("sw_c3_dout", dout, 32'hA5A5_0001);
        chk("sw_c3_level", level, 1);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        #1;
        chk("sw_empty", {valid, level}, 0);

        // underflow and clear
        pop = 1'b1;
        #1;
        chk("udf_no_cer", ram_cer, 0);
        cyc();
        pop = 1'b0;
        #1;
        chk("udf_set", udf, 1);
        chk("udf_level", level, 0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        #1;
        chk("udf_clr", udf, 0);

        // fill to full and overflow
        for (int k = 1; k <= 1027; k++) begin
            push = 1'b1;
            din  = 32'(k);
            if (k <= 1026) exp_q.push_back(din);
            if (k == 1027) begin
                #1;
                chk("ovf_no_cew", ram_cew, 0);
            end
            cyc();
            if (k == 1007) chk("afull_1007", afull, 0);
            if (k == 1008) chk("afull_1008", afull, 1);
            if (k == 1025) chk("full_1025", full, 0);
            if (k == 1026) chk("full_1026", {full, level}, {1'b1, 12'd1026});
        end
        push = 1'b0;
        #1;
        chk("ovf_set", ovf, 1);
        chk("ovf_level", {full, level}, {1'b1, 12'd1026});
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        #1;
        chk("ovf_clr", ovf, 0);
        drain(2000);
        chk("fill_end_level", level, 0);

        // streaming across pointer wrap
        d = 32'h5000_0000;
        for (int i = 0; i < 4; i++) begin
            push_word(d);
            d++;
        end
        repeat (3) cyc();
        chk("prime_level", level, 4);
        for (int i = 0; i < 5000; i++) begin
            push = 1'b1;
            pop  = 1'b1;
            din  = d;
            exp_q.push_back(d);
            d++;
            #1;
            chk("stream_valid", valid, 1);
            chk("stream_level", level, 4);
            cyc();
        end
        push = 1'b0;
        pop  = 1'b0;
        drain(100);

        // flush with a read in flight
        for (int i = 0; i < 10; i++) push_word(32'h0F00_0000 + 32'(i));
        repeat (4) cyc();
        chk("pre_flush", {valid, level}, {1'b1, 12'd10});
        pop = 1'b1;
        #1;
        chk("pre_flush_cer", ram_cer, 1);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        pop   = 1'b0;
        exp_q.delete();
        #1;
        chk("flush_valid", valid, 0);
        chk("flush_level", level, 0);
        chk("flush_ptrs", {ram_aw, ram_ar}, 0);
        cyc();
        chk("flush_drop", {valid, level}, 0);
        push_word(32'h0000_1234);
        cyc();
        cyc();
        chk("flush_push_v", valid, 1);
        chk("flush_push_d", dout, 32'h0000_1234);
        pop = 1'b1;
        cyc();
        pop = 1'b0;

        // async reset mid-stream
        d = 32'h7000_0000;
        for (int i = 0; i < 4; i++) begin
            push_word(d);
            d++;
        end
        repeat (3) cyc();
        for (int i = 0; i < 20; i++) begin
            push = 1'b1;
            pop  = 1'b1;
            din  = d;
            exp_q.push_back(d);
            d++;
            cyc();
        end
        chk("pre_rst_valid", valid, 1);
        #2;
        push = 1'b0;
        pop  = 1'b0;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_valid", valid, 0);
        chk("arst_level", level, 0);
        chk("arst_dout", dout, 0);
        chk("arst_ram", {ram_cew, ram_cer, ram_aw, ram_ar}, 0);
        chk("arst_flags", {full, afull, ovf, udf}, 0);
        cyc();
        rstn = 1'b1;
        cyc();
        push_word(32'hBEEF_0001);
        cyc();
        cyc();
        chk("post_rst_dout", {valid, dout}, {1'b1, 32'hBEEF_0001});
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
